spi_eep_resp: RTL and testbench



---
 rtl/spi_eep_resp.sv | 210 +++++++++++++++++++++
 tb/tb_spi_eep_resp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_eep_resp.sv
`default_nettype none
// ============================================================================
// Module      : spi_eep_resp
// Description : SPI mode-0 responder modelling a 64x8 calibration EEPROM.
//               Decodes 16-bit command frames {cmd[1:0], addr, wdata}. It
//               returns the response word of the previous committed frame on
//               MISO during the current frame. SCLK, SS_n and MOSI are
//               oversampled by clk, so no logic is clocked by SCLK.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               SCLK      - SPI clock from master, idles low
//               SS_n      - slave select, active low
//               MOSI      - serial command/data in, MSB first
//               MISO      - serial response out, MSB first
//               cmd_vld   - 1-clk pulse when a 16-bit frame is committed
//               frame_err - 1-clk pulse when a frame ends with a bad bit count
// Revision    : 1.0 - initial release
// ============================================================================
module spi_eep_resp #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SCLK,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic cmd_vld,
    output logic frame_err
);

    localparam int         c_FRAME_W  = 2 + ADDR_W + DATA_W;
    localparam int         c_DEPTH    = 1 << ADDR_W;
    localparam logic [4:0] c_CNT_FULL = 5'(c_FRAME_W);
    localparam logic [4:0] c_CNT_SAT  = 5'(c_FRAME_W + 1);
    localparam logic [1:0] c_CMD_READ  = 2'b00;
    localparam logic [1:0] c_CMD_WRITE = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers: [0],[1] metastability flops, [2] edge detect.
    // SS_n resets low so a select held low across reset release never
    // produces a falling edge, and therefore never a false frame start.
    // ------------------------------------------------------------------
    logic [2:0] r_sclk_sync;
    logic [2:0] r_ss_sync;
    logic [2:0] r_mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 3'b000;
            r_ss_sync   <= 3'b000;
            r_mosi_sync <= 3'b000;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
            r_ss_sync   <= {r_ss_sync[1:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[1:0], MOSI};
        end
    end

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_fall;
    logic w_ss_rise;
    logic w_mosi_bit;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
    assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
    // MOSI is taken one flop later than SCLK. The master holds it stable
    // for half an SCLK period around the rise, so this only adds margin.
    assign w_mosi_bit  = r_mosi_sync[2];

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [c_FRAME_W-1:0] r_tx_shreg;
    logic [c_FRAME_W-1:0] r_rx_shreg;
    logic [c_FRAME_W-1:0] r_resp_word;
    logic [4:0]           r_bit_cnt;
    logic [DATA_W-1:0]    r_mem [c_DEPTH];

    logic w_load_tx;
    logic w_shift_tx;
    logic w_sample_rx;
    logic w_commit;

    logic [1:0]        w_cmd;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_cmd   = r_rx_shreg[c_FRAME_W-1 -: 2];
    assign w_addr  = r_rx_shreg[DATA_W +: ADDR_W];
    assign w_wdata = r_rx_shreg[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_tx    = 1'b0;
        w_shift_tx   = 1'b0;
        w_sample_rx  = 1'b0;
        w_commit     = 1'b0;
        cmd_vld      = 1'b0;
        frame_err    = 1'b0;
        case (r_state)
            IDLE: begin
                // A select rise while idle is the tail of an aborted or
                // reset-interrupted frame, so it is deliberately ignored.
                if (w_ss_fall) begin
                    w_load_tx    = 1'b1;
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_ss_rise) begin
                    if (r_bit_cnt == c_CNT_FULL) begin
                        w_state_next = COMMIT;
                    end else begin
                        frame_err    = 1'b1;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_sample_rx = w_sclk_rise;
                    // The MSB is already on MISO from the load, so the
                    // shifting starts only at the first fall after a rise.
                    w_shift_tx  = w_sclk_fall && (r_bit_cnt != 5'd0);
                end
            end
            COMMIT: begin
                cmd_vld      = 1'b1;
                w_commit     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift registers and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shreg <= '0;
            r_rx_shreg <= '0;
            r_bit_cnt  <= 5'd0;
        end else begin
            if (w_load_tx) begin
                r_tx_shreg <= r_resp_word;
                r_bit_cnt  <= 5'd0;
            end else if (w_shift_tx) begin
                r_tx_shreg <= {r_tx_shreg[c_FRAME_W-2:0], 1'b0};
            end
            if (w_sample_rx) begin
                r_rx_shreg <= {r_rx_shreg[c_FRAME_W-2:0], w_mosi_bit};
                // Saturating just above full keeps overlong frames
                // distinguishable from exact ones.
                if (r_bit_cnt != c_CNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Calibration store and response word, updated only on commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && (w_cmd == c_CMD_WRITE)) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_word <= '0;
        end else if (w_commit) begin
            case (w_cmd)
                c_CMD_READ:  r_resp_word <= {2'b10, w_addr, r_mem[w_addr]};
                c_CMD_WRITE: r_resp_word <= {2'b01, w_addr, w_wdata};
                default:     r_resp_word <= '0;
            endcase
        end
    end

    assign MISO = (r_state == ACTIVE) ? r_tx_shreg[c_FRAME_W-1] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_eep_resp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_eep_resp
// Description : Directed self-checking bench for spi_eep_resp. A behavioural
//               mode-0 master drives frames with SCLK = clk/16; expected MISO
//               words and pulse counts are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_eep_resp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic SCLK  = 1'b0;
    logic SS_n  = 1'b1;
    logic MOSI  = 1'b0;
    logic MISO;
    logic cmd_vld;
    logic frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;

    spi_eep_resp #(
        .ADDR_W (6),
        .DATA_W (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCLK      (SCLK),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .cmd_vld   (cmd_vld),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output; a stretched pulse shows up
    // as an extra count.
    always @(negedge clk) begin
        if (cmd_vld === 1'b1)   vld_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One SCLK period: MOSI set while low, MISO sampled at the rise.
    task automatic spi_bit(input logic b, output logic m);
        MOSI = b;
        repeat (8) @(negedge clk);
        m    = MISO;
        SCLK = 1'b1;
        repeat (8) @(negedge clk);
        SCLK = 1'b0;
    endtask

    task automatic spi_xfer(input logic [15:0] tx, input int nbits, input int gap,
                            output logic [15:0] rx);
        logic m;
        rx = '0;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(tx[15-i], m);
            rx = {rx[14:0], m};
        end
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (MISO !== 1'b0) begin n_errors++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        n_checks++;
        if (cmd_vld !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_vld: got %b expected 0", cmd_vld); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (vld_cnt !== 0 || err_cnt !== 0) begin
            n_errors++;
            $display("FAIL reset_release_pulses: got vld=%0d err=%0d expected 0/0", vld_cnt, err_cnt);
        end
    endtask

    task automatic test_write_read;
        logic [15:0] rx;
        int v0;
        v0 = vld_cnt;
        spi_xfer(16'h4A5C, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h0000) begin n_errors++; $display("FAIL wr_first_miso: got %h expected 0000", rx); end
        spi_xfer(16'h0A00, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h4A5C) begin n_errors++; $display("FAIL wr_echo_miso: got %h expected 4a5c", rx); end
        n_checks++;
        if (vld_cnt - v0 !== 2) begin n_errors++; $display("FAIL wr_cmd_vld_count: got %0d expected 2", vld_cnt - v0); end
    endtask

    task automatic test_read_resp;
        logic [15:0] rx;
        spi_xfer(16'h0A00, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h8A5C) begin n_errors++; $display("FAIL read_resp_miso: got %h expected 8a5c", rx); end
    endtask

    task automatic test_abort;
        logic [15:0] rx;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        spi_xfer(16'h51AB, 10, 8, rx);
        n_checks++;
        if (rx[9:0] !== 10'h229) begin n_errors++; $display("FAIL abort_partial_miso: got %h expected 229", rx[9:0]); end
        n_checks++;
        if (err_cnt - e0 !== 1) begin n_errors++; $display("FAIL abort_frame_err: got %0d expected 1", err_cnt - e0); end
        n_checks++;
        if (vld_cnt - v0 !== 0) begin n_errors++; $display("FAIL abort_cmd_vld: got %0d expected 0", vld_cnt - v0); end
        spi_xfer(16'h1100, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h8A5C) begin n_errors++; $display("FAIL abort_resp_kept: got %h expected 8a5c", rx); end
        spi_xfer(16'h0000, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h9100) begin n_errors++; $display("FAIL abort_mem_kept: got %h expected 9100", rx); end
    endtask

    task automatic test_top_addr;
        logic [15:0] rx;
        spi_xfer(16'h7FA5, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h8000) begin n_errors++; $display("FAIL top_prev_resp: got %h expected 8000", rx); end
        spi_xfer(16'h3F00, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h7FA5) begin n_errors++; $display("FAIL top_echo: got %h expected 7fa5", rx); end
        spi_xfer(16'h0000, 16, 8, rx);
        n_checks++;
        if (rx !== 16'hBFA5) begin n_errors++; $display("FAIL top_read: got %h expected bfa5", rx); end
        spi_xfer(16'h0000, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h8000) begin n_errors++; $display("FAIL top_addr0_read: got %h expected 8000", rx); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] tx;
        logic [15:0] rx;
        logic [7:0]  tail;
        logic        m;
        int v0, e0;
        tx = 16'h5533;
        v0 = vld_cnt;
        e0 = err_cnt;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < 8; i++) spi_bit(tx[15-i], m);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (MISO !== 1'b0) begin n_errors++; $display("FAIL midrst_miso: got %b expected 0", MISO); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tail = '0;
        for (int i = 8; i < 16; i++) begin
            spi_bit(tx[15-i], m);
            tail = {tail[6:0], m};
        end
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (tail !== 8'h00) begin n_errors++; $display("FAIL midrst_tail_miso: got %h expected 00", tail); end
        n_checks++;
        if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
            n_errors++;
            $display("FAIL midrst_pulses: got vld=%0d err=%0d expected 0/0", vld_cnt - v0, err_cnt - e0);
        end
        v0 = vld_cnt;
        spi_xfer(16'h1500, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h0000) begin n_errors++; $display("FAIL midrst_resp_cleared: got %h expected 0000", rx); end
        spi_xfer(16'h1500, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h9500) begin n_errors++; $display("FAIL midrst_no_write: got %h expected 9500", rx); end
        n_checks++;
        if (vld_cnt - v0 !== 2) begin n_errors++; $display("FAIL midrst_next_frames: got %0d expected 2", vld_cnt - v0); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] rx;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        // gap 3 plus the leading negedge of the next frame = 4 clk high
        spi_xfer(16'h4066, 16, 3, rx);
        n_checks++;
        if (rx !== 16'h9500) begin n_errors++; $display("FAIL b2b_f1: got %h expected 9500", rx); end
        spi_xfer(16'hC0FF, 16, 3, rx);
        n_checks++;
        if (rx !== 16'h4066) begin n_errors++; $display("FAIL b2b_f2: got %h expected 4066", rx); end
        spi_xfer(16'h0000, 16, 3, rx);
        n_checks++;
        if (rx !== 16'h0000) begin n_errors++; $display("FAIL b2b_reserved_resp: got %h expected 0000", rx); end
        spi_xfer(16'h0000, 16, 8, rx);
        n_checks++;
        if (rx !== 16'h8066) begin n_errors++; $display("FAIL b2b_mem_unchanged: got %h expected 8066", rx); end
        n_checks++;
        if (vld_cnt - v0 !== 4) begin n_errors++; $display("FAIL b2b_cmd_vld_count: got %0d expected 4", vld_cnt - v0); end
        n_checks++;
        if (err_cnt - e0 !== 0) begin n_errors++; $display("FAIL b2b_frame_err: got %0d expected 0", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_resp();
        test_abort();
        test_top_addr();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
